// File: rtl/grid_cursor.sv
// grid_cursor: cursor for a ROWS x COLS tile board.
// Four held direction buttons move the cursor. A press moves it at once. A held direction
// auto-repeats after REPEAT_DELAY cycles, then every REPEAT_RATE cycles. At an edge the
// cursor either wraps round (WRAP=1) or is held in place (WRAP=0). Opposite buttons cancel.
// Define GRID_CURSOR_SEL_EN to add the two-cell selection ports (sel, sel_bus, sel_cnt).
module grid_cursor #(
    parameter int unsigned ROWS         = 6,
    parameter int unsigned COLS         = 6,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned REPEAT_DELAY = 24,
    parameter int unsigned REPEAT_RATE  = 8,
    parameter int unsigned RST_POS      = 0,
    localparam int unsigned RW          = $clog2(ROWS),
    localparam int unsigned CW          = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
`ifdef GRID_CURSOR_SEL_EN
    input  logic                 sel,
    output logic [ROWS*COLS-1:0] sel_bus,
    output logic [1:0]           sel_cnt,
`endif
    output logic [ROWS*COLS-1:0] cur_bus,
    output logic [RW-1:0]        row,
    output logic [CW-1:0]        col,
    output logic                 moved
);

    localparam int unsigned NPOS     = ROWS * COLS;
    localparam int unsigned CNT_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNTW     = $clog2(CNT_SPAN) + 1;

    localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(REPEAT_RATE - 1);
    localparam logic [CNTW-1:0] CNT_SAT    = {CNTW{1'b1}};
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0]   ROW_RST    = RW'(RST_POS / COLS);
    localparam logic [CW-1:0]   COL_RST    = CW'(RST_POS % COLS);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRate
    } rep_state_e;

    rep_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d, nxt_row;
    logic [CW-1:0]   col_q, col_d, nxt_col;
    logic            moved_q, moved_d;
    logic [3:0]      prev_q, prev_d;
    logic            lock_q, lock_d;
    logic [3:0]      btn;
    logic [3:0]      held;
    logic            press;
    logic            step;
    logic            v_dn, v_up, h_rt, h_lt;

    assign btn = {up, down, left, right};

    // Buttons held through reset stay masked until every button has been released,
    // so a key still down after reset cannot look like a fresh press.
    always_comb begin
        held   = lock_q ? 4'b0000 : btn;
        lock_d = lock_q & (|btn);
        prev_d = held;
        press  = |(held & ~prev_q);
    end

    // Candidate position one step away on each axis, with opposite buttons cancelling.
    always_comb begin
        v_dn    = held[2] & ~held[3];
        v_up    = held[3] & ~held[2];
        h_rt    = held[0] & ~held[1];
        h_lt    = held[1] & ~held[0];
        nxt_row = row_q;
        nxt_col = col_q;
        if (v_dn) begin
            if (row_q == ROW_LAST) begin
                nxt_row = (WRAP != 0) ? '0 : row_q;
            end else begin
                nxt_row = row_q + RW'(1);
            end
        end else if (v_up) begin
            if (row_q == '0) begin
                nxt_row = (WRAP != 0) ? ROW_LAST : row_q;
            end else begin
                nxt_row = row_q - RW'(1);
            end
        end
        if (h_rt) begin
            if (col_q == COL_LAST) begin
                nxt_col = (WRAP != 0) ? '0 : col_q;
            end else begin
                nxt_col = col_q + CW'(1);
            end
        end else if (h_lt) begin
            if (col_q == '0) begin
                nxt_col = (WRAP != 0) ? COL_LAST : col_q;
            end else begin
                nxt_col = col_q - CW'(1);
            end
        end
    end

    // Auto-repeat sequencer: decides on which cycles the held directions take a step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (held == 4'b0000) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (press) begin
            step    = 1'b1;
            state_d = StDelay;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StDelay: begin
                    if (cnt_q == DELAY_LAST) begin
                        step    = 1'b1;
                        state_d = StRate;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                StRate: begin
                    if (cnt_q == RATE_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    // Held with no new edge while idle cannot normally occur; start timing.
                    state_d = StDelay;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Commit a step; moved only when the position really changes on some axis.
    always_comb begin
        row_d   = step ? nxt_row : row_q;
        col_d   = step ? nxt_col : col_q;
        moved_d = step & ((nxt_row != row_q) | (nxt_col != col_q));
    end

    // Cursor, repeat and button-history state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= ROW_RST;
            col_q   <= COL_RST;
            moved_q <= 1'b0;
            prev_q  <= 4'b0000;
            lock_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            moved_q <= moved_d;
            prev_q  <= prev_d;
            lock_q  <= lock_d;
        end
    end

    // One-hot highlight decoded from the row/col registers.
    always_comb begin
        cur_bus = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cur_bus[r*COLS+c] = (row_q == RW'(r)) && (col_q == CW'(c));
            end
        end
    end

    assign row   = row_q;
    assign col   = col_q;
    assign moved = moved_q;

`ifdef GRID_CURSOR_SEL_EN
    logic            sel_prev_q;
    logic [NPOS-1:0] sel_bus_q, sel_bus_d;
    logic [1:0]      sel_cnt_q, sel_cnt_d;
    logic            sel_rise;
    logic            sel_hit;

    // Toggle selection of the cursor cell on a sel rising edge, at most two cells held.
    always_comb begin
        sel_bus_d = sel_bus_q;
        sel_cnt_d = sel_cnt_q;
        sel_rise  = sel & ~sel_prev_q;
        sel_hit   = |(sel_bus_q & cur_bus);
        if (sel_rise) begin
            if (sel_hit) begin
                sel_bus_d = sel_bus_q & ~cur_bus;
                sel_cnt_d = sel_cnt_q - 2'd1;
            end else if (sel_cnt_q < 2'd2) begin
                sel_bus_d = sel_bus_q | cur_bus;
                sel_cnt_d = sel_cnt_q + 2'd1;
            end
        end
    end

    // Selection storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_prev_q <= 1'b0;
            sel_bus_q  <= '0;
            sel_cnt_q  <= 2'd0;
        end else begin
            sel_prev_q <= sel;
            sel_bus_q  <= sel_bus_d;
            sel_cnt_q  <= sel_cnt_d;
        end
    end

    assign sel_bus = sel_bus_q;
    assign sel_cnt = sel_cnt_q;
`endif

endmodule

// File: tb/tb_grid_cursor.sv
// Bench for grid_cursor on a 6x6 board: a wrapping DUT, plus a clamping twin for edge cases.
// The stimulus pushes each expected move (cycle, row, col) onto a queue. The monitor pops
// one entry on every moved pulse. Selection checks are built only with GRID_CURSOR_SEL_EN.
module tb_grid_cursor;

    typedef struct {
        int cyc;
        int r;
        int c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        c_up = 1'b0, c_down = 1'b0, c_left = 1'b0, c_right = 1'b0;
    logic [35:0] cur_bus, cur_bus_c;
    logic [2:0]  row, col, row_c, col_c;
    logic        moved, moved_c;
`ifdef GRID_CURSOR_SEL_EN
    logic        sel = 1'b0;
    logic        sel_c = 1'b0;
    logic [35:0] sel_bus, sel_bus_c;
    logic [1:0]  sel_cnt, sel_cnt_c;
`endif

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grid_cursor #(.ROWS(6), .COLS(6), .WRAP(1), .REPEAT_DELAY(24), .REPEAT_RATE(8),
                  .RST_POS(0)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
`ifdef GRID_CURSOR_SEL_EN
        .sel(sel), .sel_bus(sel_bus), .sel_cnt(sel_cnt),
`endif
        .cur_bus(cur_bus), .row(row), .col(col), .moved(moved)
    );

    grid_cursor #(.ROWS(6), .COLS(6), .WRAP(0), .REPEAT_DELAY(24), .REPEAT_RATE(8),
                  .RST_POS(0)) dut_c (
        .clk(clk), .rst(rst), .up(c_up), .down(c_down), .left(c_left), .right(c_right),
`ifdef GRID_CURSOR_SEL_EN
        .sel(sel_c), .sel_bus(sel_bus_c), .sel_cnt(sel_cnt_c),
`endif
        .cur_bus(cur_bus_c), .row(row_c), .col(col_c), .moved(moved_c)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expect a move committed dt posedges from now.
    task automatic expect_move(input int dt, input int r, input int c);
        exp_t e;
        e.cyc = cyc + dt;
        e.r   = r;
        e.c   = c;
        sb.push_back(e);
    endtask

    // One-cycle press of {up,down,left,right}; mv says whether a move is expected.
    task automatic step_dirs(input logic [3:0] d, input bit mv, input int r, input int c);
        if (mv) expect_move(1, r, c);
        {up, down, left, right} = d;
        tick(1);
        {up, down, left, right} = 4'b0000;
        tick(3);
    endtask

    task automatic do_reset();
        {up, down, left, right} = 4'b0000;
        {c_up, c_down, c_left, c_right} = 4'b0000;
        rst = 1'b1;
        tick(2);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_bus", cur_bus, 36'h1);
        check("rst_moved", moved, 0);
        check("rst_row_c", row_c, 0);
        check("rst_col_c", col_c, 0);
        rst = 1'b0;
        tick(2);
    endtask

    // Monitor: every moved pulse must match the oldest expected move.
    always @(negedge clk) begin
        exp_t        e;
        logic [35:0] eb;
        if (!rst && moved) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_move: cyc %0d row %0d col %0d, required no move",
                         cyc, row, col);
            end else begin
                e  = sb.pop_front();
                eb = 36'h1 << (e.r * 6 + e.c);
                if (cyc != e.cyc || row != 3'(e.r) || col != 3'(e.c) || cur_bus !== eb) begin
                    n_fail++;
                    $display("FAIL move: got cyc %0d (%0d,%0d) bus %0h, required cyc %0d (%0d,%0d) bus %0h",
                             cyc, row, col, cur_bus, e.cyc, e.r, e.c, eb);
                end
            end
        end
    end

    // The clamping twin is only ever pushed past the edges, so it must never move.
    always @(negedge clk) begin
        if (!rst && moved_c) begin
            n_tests++;
            n_fail++;
            $display("FAIL clamp_moved: got (%0d,%0d) with moved=1, required no move", row_c, col_c);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        // 1: reset state, single right press.
        do_reset();
        step_dirs(4'b0001, 1, 0, 1);
        check("t1_bus", cur_bus, 36'h2);

        // 2: wrap upward and leftward; clamp twin stays put.
        do_reset();
        expect_move(1, 5, 0);
        up = 1'b1; c_up = 1'b1;
        tick(1);
        up = 1'b0; c_up = 1'b0;
        tick(3);
        check("t2_bus30", cur_bus, 36'h1 << 30);
        expect_move(1, 5, 5);
        left = 1'b1; c_left = 1'b1;
        tick(1);
        left = 1'b0; c_left = 1'b0;
        tick(3);
        check("t2_bus35", cur_bus, 36'h1 << 35);
        check("t2_row_c", row_c, 0);
        check("t2_col_c", col_c, 0);

        // 3: hold right from (0,2): moves at edge 0, 24, 32, 40, 48.
        do_reset();
        step_dirs(4'b0001, 1, 0, 1);
        step_dirs(4'b0001, 1, 0, 2);
        expect_move(1, 0, 3);
        expect_move(25, 0, 4);
        expect_move(33, 0, 5);
        expect_move(41, 0, 0);
        expect_move(49, 0, 1);
        right = 1'b1;
        tick(50);
        right = 1'b0;
        tick(20);
        check("t3_col", col, 1);

        // 4a: up+down cancel, right still steps.
        do_reset();
        step_dirs(4'b0100, 1, 1, 0);
        step_dirs(4'b0100, 1, 2, 0);
        step_dirs(4'b0001, 1, 2, 1);
        step_dirs(4'b0001, 1, 2, 2);
        up = 1'b1; down = 1'b1;
        tick(3);
        expect_move(1, 2, 3);
        right = 1'b1;
        tick(1);
        right = 1'b0;
        tick(3);
        up = 1'b0; down = 1'b0;
        tick(3);
        // 4b: diagonal wrap from (5,5) to (0,0).
        do_reset();
        step_dirs(4'b1000, 1, 5, 0);
        step_dirs(4'b0010, 1, 5, 5);
        step_dirs(4'b0101, 1, 0, 0);

        // 5: reset during a held repeat; held key ignored until released and re-pressed.
        do_reset();
        expect_move(1, 1, 0);
        expect_move(25, 2, 0);
        down = 1'b1;
        tick(30);
        rst = 1'b1;
        #1;
        check("t5_async_row", row, 0);
        check("t5_async_col", col, 0);
        tick(5);
        rst = 1'b0;
        tick(40);
        check("t5_hold_row", row, 0);
        check("t5_hold_col", col, 0);
        down = 1'b0;
        tick(2);
        step_dirs(4'b0100, 1, 1, 0);

`ifdef GRID_CURSOR_SEL_EN
        // 6: selection toggling, limited to two cells.
        do_reset();
        check("t6_rst_sel", sel_bus, 0);
        step_dirs(4'b0100, 1, 1, 0);
        step_dirs(4'b0001, 1, 1, 1);
        sel = 1'b1; tick(1); sel = 1'b0; tick(1);
        check("t6_bus_a", sel_bus, 36'h80);
        check("t6_cnt_a", sel_cnt, 1);
        step_dirs(4'b0001, 1, 1, 2);
        sel = 1'b1; tick(1); sel = 1'b0; tick(1);
        check("t6_bus_b", sel_bus, 36'h180);
        check("t6_cnt_b", sel_cnt, 2);
        step_dirs(4'b0001, 1, 1, 3);
        sel = 1'b1; tick(1); sel = 1'b0; tick(1);
        check("t6_bus_c", sel_bus, 36'h180);
        check("t6_cnt_c", sel_cnt, 2);
        step_dirs(4'b0010, 1, 1, 2);
        sel = 1'b1; tick(1); sel = 1'b0; tick(1);
        check("t6_bus_d", sel_bus, 36'h80);
        check("t6_cnt_d", sel_cnt, 1);
`endif

        tick(5);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
